// File: rtl/xgmii_pkt_gen_32b.sv
// xgmii_pkt_gen_32b: XGMII frame source for the 32-bit 10GBASE-R transmit path.
// Emits Start/preamble/SFD, a deterministic byte pattern, Terminate and an idle gap,
// repeated for num_pkts frames (0 = until stop).
// Optional feature macro: XGMII_GEN_CRC_EN replaces the last 4 frame bytes with the
// Ethernet CRC-32 of the preceding payload bytes.
module xgmii_pkt_gen_32b #(
  parameter int IFG_COLS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [10:0] len,
  input  logic [15:0] num_pkts,
  output logic [31:0] xgmii_txd,
  output logic [3:0]  xgmii_txc,
  output logic        busy,
  output logic [15:0] pkt_sent
);

  localparam logic [31:0] IDLE_COL = 32'h07070707;
  localparam logic [31:0] PRE0_COL = 32'h555555FB;
  localparam logic [31:0] PRE1_COL = 32'hD5555555;

  // State names the column currently on the outputs.
  typedef enum logic [2:0] {S_IDLE, S_PRE0, S_PRE1, S_DATA, S_TERM, S_IFG} state_t;

  state_t      state, state_nx;
  logic [10:0] len_q, len_nx;
  logic [15:0] num_q, num_nx;
  logic [11:0] byte_cnt, byte_cnt_nx;
  logic [7:0]  ifg_cnt, ifg_cnt_nx;
  logic [31:0] txd_nx;
  logic [3:0]  txc_nx;
  logic        busy_nx;
  logic [15:0] pkt_sent_nx;

  logic [31:0] col_d;
  logic [3:0]  col_c;
  logic        col_last;
  logic [11:0] len_w;
  logic [11:0] k;
  logic [7:0]  b;

`ifdef XGMII_GEN_CRC_EN
  logic [31:0] crc_q, crc_nx, crc_col, fcs_sh;
  logic [1:0]  off;

  // One byte of the reflected IEEE 802.3 CRC-32 (poly EDB88320).
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  function automatic logic [10:0] clamp_len(input logic [10:0] l);
    if (l < 11'd64)        return 11'd64;
    else if (l > 11'd1518) return 11'd1518;
    else                   return l;
  endfunction

  // Builds the next payload column; a column at or past the frame end carries FD then idles.
  always_comb begin
    len_w = {1'b0, len_q};
    col_d = IDLE_COL;
    col_c = 4'hF;
    k     = 12'd0;
    b     = 8'h07;
`ifdef XGMII_GEN_CRC_EN
    crc_col = crc_q;
    fcs_sh  = 32'h0;
    off     = 2'd0;
`endif
    for (int j = 0; j < 4; j++) begin
      k = byte_cnt + 12'(j);
      b = 8'h07;
      if (k < len_w) begin
        b = pkt_sent[7:0] + k[7:0];
`ifdef XGMII_GEN_CRC_EN
        if (k < len_w - 12'd4) begin
          crc_col = crc_byte(crc_col, b);
        end else begin
          // FCS byte index is (k - len + 4), always 0..3 here.
          off    = k[1:0] - len_w[1:0];
          fcs_sh = (~crc_col) >> {off, 3'b000};
          b      = fcs_sh[7:0];
        end
`endif
        col_c[j] = 1'b0;
      end else if (k == len_w) begin
        b = 8'hFD;
      end
      col_d[8*j +: 8] = b;
    end
    col_last = (byte_cnt + 12'd4) > len_w;
  end

  // Next-state and next-output logic; every output column is registered.
  always_comb begin
    state_nx    = state;
    txd_nx      = IDLE_COL;
    txc_nx      = 4'hF;
    busy_nx     = busy;
    pkt_sent_nx = pkt_sent;
    len_nx      = len_q;
    num_nx      = num_q;
    byte_cnt_nx = byte_cnt;
    ifg_cnt_nx  = ifg_cnt;
`ifdef XGMII_GEN_CRC_EN
    crc_nx      = crc_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx    = S_PRE0;
          txd_nx      = PRE0_COL;
          txc_nx      = 4'b0001;
          busy_nx     = 1'b1;
          pkt_sent_nx = 16'd0;
          len_nx      = clamp_len(len);
          num_nx      = num_pkts;
          byte_cnt_nx = 12'd0;
`ifdef XGMII_GEN_CRC_EN
          crc_nx      = 32'hFFFFFFFF;
`endif
        end
      end
      S_PRE0: begin
        state_nx = S_PRE1;
        txd_nx   = PRE1_COL;
        txc_nx   = 4'b0000;
      end
      S_PRE1, S_DATA: begin
        txd_nx      = col_d;
        txc_nx      = col_c;
        byte_cnt_nx = byte_cnt + 12'd4;
        state_nx    = col_last ? S_TERM : S_DATA;
`ifdef XGMII_GEN_CRC_EN
        crc_nx      = crc_col;
`endif
      end
      S_TERM: begin
        state_nx    = S_IFG;
        pkt_sent_nx = pkt_sent + 16'd1;
        ifg_cnt_nx  = 8'd1;
      end
      S_IFG: begin
        if (ifg_cnt == 8'(IFG_COLS)) begin
          if (stop || (num_q != 16'd0 && pkt_sent == num_q)) begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
          end else begin
            state_nx    = S_PRE0;
            txd_nx      = PRE0_COL;
            txc_nx      = 4'b0001;
            byte_cnt_nx = 12'd0;
`ifdef XGMII_GEN_CRC_EN
            crc_nx      = 32'hFFFFFFFF;
`endif
          end
        end else begin
          ifg_cnt_nx = ifg_cnt + 8'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and output registers; reset forces an idle column immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      xgmii_txd <= IDLE_COL;
      xgmii_txc <= 4'hF;
      busy      <= 1'b0;
      pkt_sent  <= 16'd0;
      len_q     <= 11'd64;
      num_q     <= 16'd0;
      byte_cnt  <= 12'd0;
      ifg_cnt   <= 8'd0;
`ifdef XGMII_GEN_CRC_EN
      crc_q     <= 32'hFFFFFFFF;
`endif
    end else begin
      state     <= state_nx;
      xgmii_txd <= txd_nx;
      xgmii_txc <= txc_nx;
      busy      <= busy_nx;
      pkt_sent  <= pkt_sent_nx;
      len_q     <= len_nx;
      num_q     <= num_nx;
      byte_cnt  <= byte_cnt_nx;
      ifg_cnt   <= ifg_cnt_nx;
`ifdef XGMII_GEN_CRC_EN
      crc_q     <= crc_nx;
`endif
    end
  end

endmodule

// File: tb/tb_xgmii_pkt_gen_32b.sv
// Scoreboard bench for xgmii_pkt_gen_32b: stimulus queues expected columns, a negedge
// monitor pops and compares them. Honours XGMII_GEN_CRC_EN in its frame model.
module tb_xgmii_pkt_gen_32b;

  localparam int IFG = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [10:0] len;
  logic [15:0] num_pkts;
  logic [31:0] xgmii_txd;
  logic [3:0]  xgmii_txc;
  logic        busy;
  logic [15:0] pkt_sent;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
    logic        b;
    logic [15:0] p;
  } col_t;

  col_t exp_q[$];

  xgmii_pkt_gen_32b #(.IFG_COLS(IFG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .len       (len),
    .num_pkts  (num_pkts),
    .xgmii_txd (xgmii_txd),
    .xgmii_txc (xgmii_txc),
    .busy      (busy),
    .pkt_sent  (pkt_sent)
  );

  always #5 clk = ~clk;

  // Monitor: one expected column per cycle while the scoreboard holds entries.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      col_t e;
      e = exp_q.pop_front();
      checks++;
      if (xgmii_txd !== e.d || xgmii_txc !== e.c || busy !== e.b || pkt_sent !== e.p) begin
        errors++;
        $display("FAIL column: got txd=%h txc=%h busy=%0b pkt_sent=%0d, required txd=%h txc=%h busy=%0b pkt_sent=%0d",
                 xgmii_txd, xgmii_txc, busy, pkt_sent, e.d, e.c, e.b, e.p);
      end
    end
  end

  function automatic logic [31:0] ref_crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push_col(input logic [31:0] d, input logic [3:0] c, input logic b,
                          input logic [15:0] p);
    col_t e;
    e.d = d; e.c = c; e.b = b; e.p = p;
    exp_q.push_back(e);
  endtask

  // Expected wire image of frame n with flen bytes, followed by the IFG.
  task automatic push_frame(input int flen, input int n, input bit last);
    logic [7:0]  sb[$];
    bit          sc[$];
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [31:0] d;
    logic [3:0]  c;
    logic [7:0]  pb;
    int          plen;
    plen = flen;
`ifdef XGMII_GEN_CRC_EN
    plen = flen - 4;
`endif
    crc = 32'hFFFFFFFF;
    for (int k = 0; k < plen; k++) begin
      pb = 8'((n + k) % 256);
      crc = ref_crc8(crc, pb);
      sb.push_back(pb);
      sc.push_back(1'b0);
    end
    fcs = ~crc;
    for (int k = plen; k < flen; k++) begin
      sb.push_back(8'(fcs >> (8 * (k - plen))));
      sc.push_back(1'b0);
    end
    sb.push_back(8'hFD);
    sc.push_back(1'b1);
    while (sb.size() % 4 != 0) begin
      sb.push_back(8'h07);
      sc.push_back(1'b1);
    end
    push_col(32'h555555FB, 4'b0001, 1'b1, 16'(n));
    push_col(32'hD5555555, 4'b0000, 1'b1, 16'(n));
    for (int i = 0; i < sb.size(); i += 4) begin
      d = {sb[i+3], sb[i+2], sb[i+1], sb[i]};
      c = {sc[i+3], sc[i+2], sc[i+1], sc[i]};
      push_col(d, c, 1'b1, 16'(n));
    end
    for (int i = 0; i < IFG; i++) push_col(32'h07070707, 4'hF, 1'b1, 16'(n + 1));
    if (last) push_col(32'h07070707, 4'hF, 1'b0, 16'(n + 1));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic issue_start(input logic [10:0] l, input logic [15:0] np);
    @(negedge clk);
    len = l;
    num_pkts = np;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d columns outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    len = 11'd64;
    num_pkts = 16'd1;
    repeat (2) @(negedge clk);
    check("reset_txd", xgmii_txd, 32'h07070707);
    check("reset_txc", {28'h0, xgmii_txc}, 32'hF);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_pkt_sent", {16'h0, pkt_sent}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // len=64, single frame
    issue_start(11'd64, 16'd1);
    push_frame(64, 0, 1'b1);
    wait_drain("len64", 200);
    check("len64_pkt_sent", {16'h0, pkt_sent}, 32'd1);

    // len=65: partial last column carries the terminate
    issue_start(11'd65, 16'd1);
    push_frame(65, 0, 1'b1);
    wait_drain("len65", 200);

    // clamping at both ends
    issue_start(11'd10, 16'd1);
    push_frame(64, 0, 1'b1);
    wait_drain("len10_clamp", 200);
    issue_start(11'd2000, 16'd1);
    push_frame(1518, 0, 1'b1);
    wait_drain("len2000_clamp", 2000);

    // three back-to-back frames
    issue_start(11'd64, 16'd3);
    push_frame(64, 0, 1'b0);
    push_frame(64, 1, 1'b0);
    push_frame(64, 2, 1'b1);
    wait_drain("three_frames", 300);
    check("three_pkt_sent", {16'h0, pkt_sent}, 32'd3);
    check("three_busy", {31'h0, busy}, 32'h0);

    // free-running, stop mid second frame; start/len pulses while busy are ignored
    issue_start(11'd64, 16'd0);
    push_frame(64, 0, 1'b0);
    push_frame(64, 1, 1'b1);
    repeat (25) @(posedge clk);
    #1 start = 1'b1;
    len = 11'd100;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 stop = 1'b1;
    wait_drain("stop_run", 300);
    stop = 1'b0;
    check("stop_pkt_sent", {16'h0, pkt_sent}, 32'd2);
    check("stop_busy", {31'h0, busy}, 32'h0);

    // async reset in the middle of the payload
    issue_start(11'd64, 16'd1);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", {31'h0, busy}, 32'h1);
`ifndef XGMII_GEN_CRC_EN
    check("mid_data", xgmii_txd, 32'h0F0E0D0C);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_txd", xgmii_txd, 32'h07070707);
    check("async_rst_txc", {28'h0, xgmii_txc}, 32'hF);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_rst_txd", xgmii_txd, 32'h07070707);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
